mux_scan_n_1: RTL and testbench
===============================

MUX_SCAN_N_1 -- requirements
Module: MUX_Scan_N_1

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bit width of each data channel.
REQ-002 Parameter CHANNELS, default 16: number of input channels, range 2..64.
REQ-003 Parameter SEL_WIDTH, default $clog2(CHANNELS): width of the channel index.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Clock_In  input  1  rising-edge system clock.
REQ-006 Reset_N_In  input  1  asynchronous active-low reset.
REQ-007 Enable_In  input  1  block enable; low tri-states the data output and halts sampling.
REQ-008 Mode_In  input  1  0 = manual select, 1 = automatic round-robin scan.
REQ-009 Select_In  input  SEL_WIDTH  channel index used in manual mode.
REQ-010 Channel_Mask_In  input  CHANNELS  bit i = 1 includes channel i in the scan.
REQ-011 Data_In  input  CHANNELS*DATA_WIDTH  flattened channels; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Out_Ready_In  input  1  downstream accepts the current sample.
REQ-013 MUX_Data_Out  output  DATA_WIDTH  registered sample, or Z while Enable_In is low.
REQ-014 MUX_Valid_Out  output  1  MUX_Data_Out holds an unconsumed sample.
REQ-015 Channel_Out  output  SEL_WIDTH  index of the channel held in MUX_Data_Out.
REQ-016 Scan_Wrap_Out  output  1  one-cycle pulse when the scan pointer wraps from a higher index to a lower one.

Function
REQ-017 Output stage: a valid/ready register; the transfer occurs on a clock edge where MUX_Valid_Out and Out_Ready_In are both 1.
REQ-018 Load rule: the register loads a new sample when Enable_In=1 and (MUX_Valid_Out=0 or a transfer occurs); otherwise it holds data, channel and valid.
REQ-019 Latency: the sampled value is the channel data present on the loading edge and appears on MUX_Data_Out one cycle later.
REQ-020 Manual mode: the loaded channel is Select_In.
REQ-020a Manual mode: Select_In >= CHANNELS loads no sample, and MUX_Valid_Out is cleared if a transfer occurs.
REQ-021 Scan mode: the loaded channel is the next masked-in index strictly after the scan pointer, searching upward modulo CHANNELS.
REQ-021a Scan mode: after each load, the scan pointer takes the index just loaded.
REQ-022 Scan mode, single channel: if only the pointer's own channel is masked in, that channel is reloaded repeatedly.
REQ-023 Scan mode, empty mask: if Channel_Mask_In is all zero, no load occurs, MUX_Valid_Out falls after a pending transfer, and the pointer holds.
REQ-024 Wrap pulse: Scan_Wrap_Out=1 for exactly one cycle, coincident with the first valid cycle of a sample whose index is <= the previous pointer.
REQ-025 Mode switch: switching Mode_In from 0 to 1 resets the scan pointer to CHANNELS-1, so the first scan load searches from channel 0.
REQ-025a Mode switch: a held sample is never discarded by a mode change.
REQ-026 Enable low: when Enable_In=0, MUX_Data_Out=Z combinationally and MUX_Valid_Out=0.
REQ-026a Enable low: the held channel, data and pointer are retained, and sampling resumes on the first edge after Enable_In returns to 1.
REQ-027 Mask change: mask changes take effect on the next search; an already-held sample is unaffected.
REQ-028 Simultaneous transfer and load: back-to-back samples, one per cycle, are produced with no bubble while Out_Ready_In=1.

Reset
REQ-029 While Reset_N_In=0: MUX_Valid_Out=0, Scan_Wrap_Out=0, Channel_Out=0, internal data register=0, scan pointer=CHANNELS-1.
REQ-030 Reset asserted mid-transfer discards the held sample with no partial output.
REQ-031 After reset release, the first load occurs on the first rising edge with Enable_In=1.

Structure
REQ-032 Package MUX_Scan_Pkg: mode enum (MODE_MANUAL, MODE_SCAN) and an index-width function.
REQ-033 One sub-module, MUX_RR_Next_Finder: combinational masked round-robin search returning the next index, a found flag and a wrap flag.

Verification
REQ-034 Manual mode, CHANNELS=16, Data ch5=8'hA5, Select_In=5, ready=1 -> MUX_Data_Out=8'hA5, Channel_Out=5, valid one cycle after the load edge.
REQ-035 Scan mode, mask=16'h0091 (ch0, 4, 7), ready=1 -> Channel_Out sequence 0,4,7,0,4; Scan_Wrap_Out pulses with each return to 0 after 7.
REQ-036 Backpressure, ready=0 for 3 cycles -> data and Channel_Out held stable, valid=1; ready=1 -> next channel follows with no bubble.
REQ-037 Empty mask while valid=1, then ready=1 -> one transfer, then valid=0 and pointer unchanged; mask=16'h0001 -> ch0 reloads every cycle.
REQ-038 Enable_In=0 mid-scan -> MUX_Data_Out=Z and valid=0; Enable_In=1 -> scan resumes at the next masked index after the retained pointer.
REQ-039 Reset asserted mid-scan -> outputs at reset values at once; after release in scan mode, first Channel_Out = lowest masked-in index.

Source files
------------

// File: rtl/MUX_Scan_Pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
package MUX_Scan_Pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // Width of an index able to address n channels (never narrower than one bit).
   function automatic int index_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/MUX_RR_Next_Finder.sv
// Combinational masked round-robin search: first masked-in index strictly after
// i_ptr (modulo CHANNELS), with i_ptr itself as the last candidate.
module MUX_RR_Next_Finder #(
   parameter int CHANNELS  = 16,
   parameter int SEL_WIDTH = 4
) (
   input  logic [CHANNELS-1:0]  i_mask,
   input  logic [SEL_WIDTH-1:0] i_ptr,
   output logic [SEL_WIDTH-1:0] o_idx,
   output logic                 o_found,
   output logic                 o_wrap
);

   logic [SEL_WIDTH:0] w_sum;
   logic [SEL_WIDTH:0] w_cand;
   logic               w_hit;

   // Walk from the farthest candidate to the nearest so the nearest hit wins;
   // a candidate reached by wrapping past the top is <= i_ptr.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      o_wrap  = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      w_hit   = 1'b0;
      for (int k = CHANNELS; k >= 1; k--) begin
         w_sum = {1'b0, i_ptr} + (SEL_WIDTH+1)'(k);
         if (w_sum >= (SEL_WIDTH+1)'(CHANNELS)) begin
            w_cand = w_sum - (SEL_WIDTH+1)'(CHANNELS);
         end else begin
            w_cand = w_sum;
         end
         w_hit   = i_mask[w_cand[SEL_WIDTH-1:0]];
         o_idx   = w_hit ? w_cand[SEL_WIDTH-1:0] : o_idx;
         o_wrap  = w_hit ? (w_sum >= (SEL_WIDTH+1)'(CHANNELS)) : o_wrap;
         o_found = o_found | w_hit;
      end
   end

endmodule

// File: rtl/mux_scan_n_1.sv
// N-to-1 channel multiplexer with manual or round-robin scan selection and a
// valid/ready registered output stage.
module mux_scan_n_1
   import MUX_Scan_Pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 16,
   parameter int SEL_WIDTH  = index_width(CHANNELS)
) (
   input  logic                           Clock_In,
   input  logic                           Reset_N_In,
   input  logic                           Enable_In,
   input  logic                           Mode_In,
   input  logic [SEL_WIDTH-1:0]           Select_In,
   input  logic [CHANNELS-1:0]            Channel_Mask_In,
   input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
   input  logic                           Out_Ready_In,
   output logic [DATA_WIDTH-1:0]          MUX_Data_Out,
   output logic                           MUX_Valid_Out,
   output logic [SEL_WIDTH-1:0]           Channel_Out,
   output logic                           Scan_Wrap_Out
);

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(CHANNELS - 1);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [SEL_WIDTH-1:0]  r_chan;
   logic [SEL_WIDTH-1:0]  r_ptr;
   logic                  r_wrap;
   mode_e                 r_mode_prev;

   mode_e                 w_mode;
   logic                  w_scan;
   logic                  w_switch;
   logic [SEL_WIDTH-1:0]  w_ptr_eff;
   logic [SEL_WIDTH-1:0]  w_f_idx;
   logic                  w_f_found;
   logic                  w_f_wrap;
   logic                  w_xfer;
   logic                  w_slot;
   logic                  w_sel_ok;
   logic                  w_load;
   logic [SEL_WIDTH-1:0]  w_idx;
   logic [DATA_WIDTH-1:0] w_sample;

   assign w_mode    = mode_e'(Mode_In);
   assign w_scan    = (w_mode == MODE_SCAN);
   // Entering scan mode restarts the search so channel 0 is tried first.
   assign w_switch  = w_scan && (r_mode_prev == MODE_MANUAL);
   assign w_ptr_eff = w_switch ? LAST_IDX : r_ptr;

   MUX_RR_Next_Finder #(
      .CHANNELS  (CHANNELS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_finder (
      .i_mask  (Channel_Mask_In),
      .i_ptr   (w_ptr_eff),
      .o_idx   (w_f_idx),
      .o_found (w_f_found),
      .o_wrap  (w_f_wrap)
   );

   assign w_xfer   = Enable_In & r_valid & Out_Ready_In;
   assign w_slot   = Enable_In & (~r_valid | w_xfer);
   assign w_sel_ok = ({1'b0, Select_In} < (SEL_WIDTH+1)'(CHANNELS));
   assign w_idx    = w_scan ? w_f_idx : Select_In;
   assign w_load   = w_slot & (w_scan ? w_f_found : w_sel_ok);
   assign w_sample = Data_In[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

   // Output register, scan pointer and wrap pulse.
   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_chan      <= '0;
         r_ptr       <= LAST_IDX;
         r_wrap      <= 1'b0;
         r_mode_prev <= MODE_MANUAL;
      end else begin
         r_mode_prev <= w_mode;
         r_ptr       <= (w_load && w_scan) ? w_f_idx : w_ptr_eff;
         r_wrap      <= w_load & w_scan & w_f_wrap;
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_sample;
            r_chan  <= w_idx;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end
      end
   end

   assign MUX_Data_Out  = Enable_In ? r_data : {DATA_WIDTH{1'bz}};
   assign MUX_Valid_Out = r_valid & Enable_In;
   assign Channel_Out   = r_chan;
   assign Scan_Wrap_Out = r_wrap;

endmodule

// File: tb/tb_mux_scan_n_1.sv
// Randomized and directed bench for mux_scan_n_1 against a behavioural model.
module tb_mux_scan_n_1;

   localparam int DW = 8;
   localparam int CH = 16;
   localparam int SW = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b1;
   logic             mode = 1'b0;
   logic [SW-1:0]    sel = '0;
   logic [CH-1:0]    mask = '0;
   logic [CH*DW-1:0] din = '0;
   logic             rdy = 1'b0;
   wire  [DW-1:0]    dout;
   logic             vout;
   logic [SW-1:0]    chout;
   logic             wrap;

   int n_tests = 0;
   int n_fail  = 0;

   bit            m_valid;
   bit            m_wrap;
   bit            m_prev_scan;
   int            m_chan;
   int            m_ptr;
   logic [DW-1:0] m_data;

   mux_scan_n_1 #(.DATA_WIDTH(DW), .CHANNELS(CH), .SEL_WIDTH(SW)) dut (
      .Clock_In        (clk),
      .Reset_N_In      (rst_n),
      .Enable_In       (en),
      .Mode_In         (mode),
      .Select_In       (sel),
      .Channel_Mask_In (mask),
      .Data_In         (din),
      .Out_Ready_In    (rdy),
      .MUX_Data_Out    (dout),
      .MUX_Valid_Out   (vout),
      .Channel_Out     (chout),
      .Scan_Wrap_Out   (wrap)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid     = 1'b0;
      m_wrap      = 1'b0;
      m_prev_scan = 1'b0;
      m_chan      = 0;
      m_ptr       = CH - 1;
      m_data      = '0;
   endtask

   // One clock edge of the reference behaviour, from the current inputs.
   task automatic model_edge();
      bit xfer;
      bit found;
      int ptr;
      int idx;
      xfer   = en && m_valid && rdy;
      ptr    = (mode && !m_prev_scan) ? CH - 1 : m_ptr;
      m_wrap = 1'b0;
      if (en && (!m_valid || xfer)) begin
         found = 1'b0;
         idx   = 0;
         if (!mode) begin
            idx   = int'(sel);
            found = (idx < CH);
         end else begin
            for (int k = 1; k <= CH && !found; k++) begin
               if (mask[(ptr + k) % CH]) begin
                  found = 1'b1;
                  idx   = (ptr + k) % CH;
               end
            end
         end
         if (found) begin
            if (mode) begin
               m_wrap = (idx <= ptr);
               ptr    = idx;
            end
            m_valid = 1'b1;
            m_chan  = idx;
            m_data  = din[idx*DW +: DW];
         end else if (xfer) begin
            m_valid = 1'b0;
         end
      end
      m_ptr       = ptr;
      m_prev_scan = mode;
   endtask

   task automatic check_outputs();
      check_value("valid", 32'(vout), 32'(en && m_valid));
      check_value("chan", 32'(chout), 32'(m_chan));
      check_value("wrap", 32'(wrap), 32'(m_wrap));
      if (en) begin
         check_value("data", 32'(dout), 32'(m_data));
      end else begin
         check_value("data_z", 32'((dout === {DW{1'bz}}) || (dout === '0)), 32'd1);
      end
   endtask

   task automatic cycle();
      if (!rst_n) model_reset();
      else model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic rand_data();
      for (int c = 0; c < CH; c++) din[c*DW +: DW] = DW'($urandom);
   endtask

   initial begin
      int exp_ch[5];
      int exp_wr[5];
      exp_ch = '{0, 4, 7, 0, 4};
      exp_wr = '{1, 0, 0, 1, 0};
      rand_data();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();

      // Manual select of channel 5
      rst_n = 1'b1;
      din[5*DW +: DW] = 8'hA5;
      sel = 4'd5;
      rdy = 1'b1;
      cycle();
      check_value("r034_data", 32'(dout), 32'h0000_00A5);
      check_value("r034_chan", 32'(chout), 32'd5);

      // Scan over ch 0, 4, 7
      mode = 1'b1;
      mask = 16'h0091;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         cycle();
         check_value("r035_chan", 32'(chout), 32'(exp_ch[i]));
         check_value("r035_wrap", 32'(wrap), 32'(exp_wr[i]));
      end

      // Backpressure
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         cycle();
         check_value("r036_hold", 32'(chout), 32'd4);
      end
      rdy = 1'b1;
      cycle();
      check_value("r036_next", 32'(chout), 32'd7);

      // Empty mask drains, pointer holds at 7
      rdy = 1'b0;
      cycle();
      mask = 16'h0000;
      rdy = 1'b1;
      cycle();
      check_value("r037_drain", 32'(vout), 32'd0);
      cycle();
      mask = 16'h0180;
      cycle();
      check_value("r037_ptr", 32'(chout), 32'd8);
      mask = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         cycle();
         check_value("r037_single", 32'(chout), 32'd0);
         check_value("r037_single_v", 32'(vout), 32'd1);
      end

      // Enable low mid-scan
      mask = 16'h0091;
      cycle();
      en = 1'b0;
      #1;
      check_outputs();
      for (int i = 0; i < 2; i++) begin
         rand_data();
         cycle();
      end
      en = 1'b1;
      cycle();
      check_value("r038_resume", 32'(chout), 32'd7);

      // Reset mid-scan
      cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_value("r039_valid", 32'(vout), 32'd0);
      check_value("r039_chan", 32'(chout), 32'd0);
      check_outputs();
      cycle();
      mask = 16'h0090;
      rst_n = 1'b1;
      cycle();
      check_value("r039_first", 32'(chout), 32'd4);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         en    = ($urandom_range(0, 9) != 0);
         rdy   = ($urandom_range(0, 9) < 7);
         sel   = SW'($urandom);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 7))
               0:       mask = '0;
               1:       mask = CH'(1) << $urandom_range(0, CH - 1);
               2:       mask = '1;
               default: mask = CH'($urandom & $urandom);
            endcase
         end
         rand_data();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
